// File: rtl/key_select_debounce.sv
// key_select_debounce: synchronise and debounce two active-low buttons into a select code.
// Define KEYSEL_TOGGLE_EN for tap-to-toggle selection instead of level-following.
module key_select_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  output logic [1:0] key_sel,
  output logic       sel_change,
  output logic       busy
);

  typedef enum logic {
    ST_STABLE,
    ST_COUNTING
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] stable;
  logic [1:0] cnt_busy;
  logic [1:0] sel_nx;

  for (genvar i = 0; i < 2; i++) begin : g_bit
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             lvl;
    logic             lvl_nx;
    logic             diff;

    assign diff = sync_b[i] ^ lvl;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_STABLE;
        cnt   <= '0;
        lvl   <= 1'b1;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        lvl   <= lvl_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      lvl_nx   = lvl;
      unique case (state)
        ST_STABLE: begin
          if (diff) begin
            // a one-cycle window accepts on the very first mismatch
            if (DEBOUNCE_CYCLES == 1) begin
              lvl_nx = sync_b[i];
            end else begin
              state_nx = ST_COUNTING;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        ST_COUNTING: begin
          if (!diff) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
            lvl_nx   = sync_b[i];
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign stable[i]   = lvl;
    assign cnt_busy[i] = (cnt_nx != '0);
  end

`ifdef KEYSEL_TOGGLE_EN
  logic [1:0] stable_q;

  always_ff @(posedge clk) begin
    if (rst) stable_q <= 2'b11;
    else     stable_q <= stable;
  end

  // an accepted press is a 1->0 step of the debounced level
  assign sel_nx = key_sel ^ (stable_q & ~stable);
`else
  assign sel_nx = ~stable;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      key_sel    <= 2'b00;
      sel_change <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_a     <= key_n;
      sync_b     <= sync_a;
      key_sel    <= sel_nx;
      sel_change <= (sel_nx != key_sel);
      busy       <= |cnt_busy;
    end
  end

endmodule

// File: tb/tb_key_select_debounce.sv
// Testbench for key_select_debounce: directed scenarios plus random buttons
// checked every cycle against a run-length behavioural model.
module tb_key_select_debounce;

  localparam int DEB = 4;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic [1:0] key_sel;
  logic       sel_change;
  logic       busy;

  key_select_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .key_sel(key_sel),
    .sel_change(sel_change),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, $signed(got), $signed(exp), $time);
  endtask

  // Model: button history pipeline, accepted level, and length of the
  // current run of samples disagreeing with the accepted level.
  logic [1:0] m_s1, m_s2, m_stab, m_prev, m_sel;
  logic       m_chg, m_busy;
  bit         m_ok = 1'b0;
  int         m_run [2];

  always @(posedge clk) begin
    logic [1:0] nsel;
    if (rst) begin
      m_s1 = 2'b11; m_s2 = 2'b11;
      m_stab = 2'b11; m_prev = 2'b11;
      m_sel = 2'b00; m_chg = 1'b0; m_busy = 1'b0;
      m_run[0] = 0; m_run[1] = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
`ifdef KEYSEL_TOGGLE_EN
      nsel = m_sel ^ (m_prev & ~m_stab);
`else
      nsel = ~m_stab;
`endif
      m_chg  = (nsel != m_sel);
      m_sel  = nsel;
      m_prev = m_stab;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_stab[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_busy = (m_run[0] != 0) || (m_run[1] != 0);
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("sel", 32'(key_sel), 32'(m_sel));
      check("chg", 32'(sel_change), 32'(m_chg));
      check("busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic do_reset(input int n, input logic [1:0] k);
    rst = 1'b1;
    key_n = k;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check("rst_sel", 32'(key_sel), 0);
      check("rst_chg", 32'(sel_change), 0);
      check("rst_busy", 32'(busy), 0);
    end
    rst = 1'b0;
  endtask

  // lat: edges from first sampling edge to the key_sel change (-1 = none)
  task automatic measure(input int max, output int lat, output int pulses,
                         output int busy_n, output logic [1:0] val);
    logic [1:0] start;
    start = key_sel;
    lat = -1; pulses = 0; busy_n = 0; val = start;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel_change) pulses++;
      if (lat < 0 && busy) busy_n++;
      if (lat < 0 && key_sel != start) begin
        lat = k - 1;
        val = key_sel;
      end
    end
  endtask

  int lat, pl, bn, hold;
  logic [1:0] v;

  initial begin
    rst = 1'b1;
    key_n = 2'b00;

    // reset with both held, then simultaneous acceptance
    do_reset(2, 2'b00);
    measure(12, lat, pl, bn, v);
    check("both_lat", lat, 6);
    check("both_val", 32'(v), 3);
    check("both_pulses", pl, 1);

    key_n = 2'b11;
    measure(12, lat, pl, bn, v);
`ifdef KEYSEL_TOGGLE_EN
    check("both_rel_lat", lat, -1);
    check("both_rel_pulses", pl, 0);
`else
    check("both_rel_lat", lat, 6);
    check("both_rel_val", 32'(v), 0);
    check("both_rel_pulses", pl, 1);
`endif

    // clean press of button 0
    do_reset(1, 2'b11);
    key_n = 2'b10;
    measure(12, lat, pl, bn, v);
    check("press_lat", lat, 6);
    check("press_val", 32'(v), 1);
    check("press_pulses", pl, 1);
    check("press_busy_cycles", bn, 3);

    // bounce on button 1
    do_reset(1, 2'b11);
    key_n = 2'b01;
    repeat (3) @(negedge clk);
    key_n = 2'b11;
    @(negedge clk);
    key_n = 2'b01;
    measure(12, lat, pl, bn, v);
    check("bounce_lat", lat, 6);
    check("bounce_val", 32'(v), 2);
    check("bounce_pulses", pl, 1);

    // reset in the middle of a count
    do_reset(1, 2'b11);
    key_n = 2'b10;
    repeat (4) @(negedge clk);
    check("midcnt_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midcnt_busy", 32'(busy), 0);
    check("midcnt_sel", 32'(key_sel), 0);
    rst = 1'b0;
    key_n = 2'b11;
    measure(10, lat, pl, bn, v);
    check("midcnt_lat", lat, -1);
    check("midcnt_pulses", pl, 0);

`ifdef KEYSEL_TOGGLE_EN
    do_reset(1, 2'b11);
    key_n = 2'b10;
    measure(8, lat, pl, bn, v);
    check("tap1_val", 32'(v), 1);
    check("tap1_pulses", pl, 1);
    key_n = 2'b11;
    measure(8, lat, pl, bn, v);
    check("tap1_rel_pulses", pl, 0);
    key_n = 2'b10;
    measure(8, lat, pl, bn, v);
    check("tap2_val", 32'(v), 0);
    check("tap2_pulses", pl, 1);
    key_n = 2'b11;
    measure(8, lat, pl, bn, v);
    check("tap2_rel_pulses", pl, 0);
`endif

    // random buttons with occasional reset
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        key_n = 2'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
